// File: rtl/jtag_tap_responder.sv
// JTAG TAP target that oversamples TCK/TMS/TDI/TRSTn on the system clock.
// Provides the standard 16-state TAP controller with IDCODE, BYPASS and USER data registers.
`timescale 1ns/1ps
module jtag_tap_responder #(
  parameter int                  IR_WIDTH     = 5,
  parameter int                  DR_WIDTH     = 32,
  parameter logic [31:0]         IDCODE_VALUE = 32'h0EE19401,
  parameter logic [IR_WIDTH-1:0] IDCODE_INST  = 5'h01,
  parameter logic [IR_WIDTH-1:0] USER_INST    = 5'h10
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                io_jtag_TCK,
  input  logic                io_jtag_TMS,
  input  logic                io_jtag_TDI,
  input  logic                io_jtag_TRSTn,
  output logic                io_jtag_TDO,
  output logic                io_jtag_TDO_en,
  input  logic [DR_WIDTH-1:0] user_capture_data,
  output logic [DR_WIDTH-1:0] user_update_data,
  output logic                user_update_valid,
  output logic [3:0]          tap_state,
  output logic [IR_WIDTH-1:0] ir_value
);

  typedef enum logic [3:0] {
    TLR      = 4'd0,  RTI      = 4'd1,  SEL_DR   = 4'd2,  CAP_DR   = 4'd3,
    SHIFT_DR = 4'd4,  EXIT1_DR = 4'd5,  PAUSE_DR = 4'd6,  EXIT2_DR = 4'd7,
    UPD_DR   = 4'd8,  SEL_IR   = 4'd9,  CAP_IR   = 4'd10, SHIFT_IR = 4'd11,
    EXIT1_IR = 4'd12, PAUSE_IR = 4'd13, EXIT2_IR = 4'd14, UPD_IR   = 4'd15
  } tap_state_t;

  logic [2:0]          r_tckSync;
  logic [1:0]          r_tmsSync;
  logic [1:0]          r_tdiSync;
  logic [1:0]          r_trstnSync;
  tap_state_t          r_state;
  logic [IR_WIDTH-1:0] r_irValue;
  logic [IR_WIDTH-1:0] r_irShift;
  logic [31:0]         r_idShift;
  logic [DR_WIDTH-1:0] r_userShift;
  logic                r_bypass;
  logic                r_tdo;
  logic                r_tdoEn;
  logic [DR_WIDTH-1:0] r_updData;
  logic                r_updValid;

  logic       w_tckRise;
  logic       w_tckFall;
  logic       w_tms;
  logic       w_tdi;
  logic       w_trst;
  logic       w_selId;
  logic       w_selUser;
  logic       w_drLsb;
  tap_state_t w_nextState;

  function automatic tap_state_t nextState(input tap_state_t s, input logic tms);
    case (s)
      TLR:      nextState = tms ? TLR      : RTI;
      RTI:      nextState = tms ? SEL_DR   : RTI;
      SEL_DR:   nextState = tms ? SEL_IR   : CAP_DR;
      CAP_DR:   nextState = tms ? EXIT1_DR : SHIFT_DR;
      SHIFT_DR: nextState = tms ? EXIT1_DR : SHIFT_DR;
      EXIT1_DR: nextState = tms ? UPD_DR   : PAUSE_DR;
      PAUSE_DR: nextState = tms ? EXIT2_DR : PAUSE_DR;
      EXIT2_DR: nextState = tms ? UPD_DR   : SHIFT_DR;
      UPD_DR:   nextState = tms ? SEL_DR   : RTI;
      SEL_IR:   nextState = tms ? TLR      : CAP_IR;
      CAP_IR:   nextState = tms ? EXIT1_IR : SHIFT_IR;
      SHIFT_IR: nextState = tms ? EXIT1_IR : SHIFT_IR;
      EXIT1_IR: nextState = tms ? UPD_IR   : PAUSE_IR;
      PAUSE_IR: nextState = tms ? EXIT2_IR : PAUSE_IR;
      EXIT2_IR: nextState = tms ? UPD_IR   : SHIFT_IR;
      UPD_IR:   nextState = tms ? SEL_DR   : RTI;
      default:  nextState = TLR;
    endcase
  endfunction

  // Bit 1 of each chain is the synchronized value; TCK bit 2 is the previous sample for edge detection.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_tckSync   <= 3'b000;
      r_tmsSync   <= 2'b00;
      r_tdiSync   <= 2'b00;
      r_trstnSync <= 2'b11;
    end else begin
      r_tckSync   <= {r_tckSync[1:0], io_jtag_TCK};
      r_tmsSync   <= {r_tmsSync[0], io_jtag_TMS};
      r_tdiSync   <= {r_tdiSync[0], io_jtag_TDI};
      r_trstnSync <= {r_trstnSync[0], io_jtag_TRSTn};
    end
  end

  assign w_tckRise   = r_tckSync[1] & ~r_tckSync[2];
  assign w_tckFall   = ~r_tckSync[1] & r_tckSync[2];
  assign w_tms       = r_tmsSync[1];
  assign w_tdi       = r_tdiSync[1];
  assign w_trst      = ~r_trstnSync[1];
  assign w_selId     = (r_irValue == IDCODE_INST);
  assign w_selUser   = (r_irValue == USER_INST);
  assign w_drLsb     = w_selId ? r_idShift[0] : (w_selUser ? r_userShift[0] : r_bypass);
  assign w_nextState = nextState(r_state, w_tms);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= TLR;
      r_irValue   <= IDCODE_INST;
      r_irShift   <= '0;
      r_idShift   <= '0;
      r_userShift <= '0;
      r_bypass    <= 1'b0;
      r_tdo       <= 1'b0;
      r_tdoEn     <= 1'b0;
      r_updData   <= '0;
      r_updValid  <= 1'b0;
    end else begin
      r_updValid <= 1'b0;
      if (w_trst) begin
        r_state   <= TLR;
        r_irValue <= IDCODE_INST;
        r_tdo     <= 1'b0;
        r_tdoEn   <= 1'b0;
      end else if (w_tckRise) begin
        // Capture and shift act on the state held before this TCK rise.
        case (r_state)
          CAP_IR:   r_irShift <= {{(IR_WIDTH-2){1'b0}}, 2'b01};
          SHIFT_IR: r_irShift <= {w_tdi, r_irShift[IR_WIDTH-1:1]};
          CAP_DR: begin
            if (w_selId)        r_idShift   <= IDCODE_VALUE;
            else if (w_selUser) r_userShift <= user_capture_data;
            else                r_bypass    <= 1'b0;
          end
          SHIFT_DR: begin
            if (w_selId)        r_idShift   <= {w_tdi, r_idShift[31:1]};
            else if (w_selUser) r_userShift <= {w_tdi, r_userShift[DR_WIDTH-1:1]};
            else                r_bypass    <= w_tdi;
          end
          default: ;
        endcase
        r_state <= w_nextState;
        if (w_nextState == TLR) r_irValue <= IDCODE_INST;
      end else if (w_tckFall) begin
        if (r_state == SHIFT_IR) begin
          r_tdo   <= r_irShift[0];
          r_tdoEn <= 1'b1;
        end else if (r_state == SHIFT_DR) begin
          r_tdo   <= w_drLsb;
          r_tdoEn <= 1'b1;
        end else begin
          r_tdo   <= 1'b0;
          r_tdoEn <= 1'b0;
        end
        if (r_state == UPD_IR) r_irValue <= r_irShift;
        if (r_state == UPD_DR && w_selUser) begin
          r_updData  <= r_userShift;
          r_updValid <= 1'b1;
        end
      end
    end
  end

  assign io_jtag_TDO       = r_tdo;
  assign io_jtag_TDO_en    = r_tdoEn;
  assign user_update_data  = r_updData;
  assign user_update_valid = r_updValid;
  assign tap_state         = r_state;
  assign ir_value          = r_irValue;

endmodule

// File: tb/tb_jtag_tap_responder.sv
// Scoreboard bench for jtag_tap_responder: a bit-queue TAP model predicts every TCK-rise observation
// and every USER update; independent monitors pop and compare.
`timescale 1ns/1ps
module tb_jtag_tap_responder;

  localparam logic [31:0] IDCODE_VALUE = 32'h0EE19401;
  localparam logic [4:0]  IDCODE_INST  = 5'h01;
  localparam logic [4:0]  USER_INST    = 5'h10;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        tck = 1'b0;
  logic        tms = 1'b1;
  logic        tdi = 1'b0;
  logic        trstn = 1'b1;
  logic [31:0] userCapture = 32'h0;
  logic        tdo;
  logic        tdoEn;
  logic [31:0] userUpdate;
  logic        updValid;
  logic [3:0]  tapState;
  logic [4:0]  irValue;

  jtag_tap_responder dut (
    .clock(clock), .reset(reset),
    .io_jtag_TCK(tck), .io_jtag_TMS(tms), .io_jtag_TDI(tdi), .io_jtag_TRSTn(trstn),
    .io_jtag_TDO(tdo), .io_jtag_TDO_en(tdoEn),
    .user_capture_data(userCapture), .user_update_data(userUpdate), .user_update_valid(updValid),
    .tap_state(tapState), .ir_value(irValue)
  );

  always #5 clock = ~clock;

  typedef struct {
    int         state;
    logic [4:0] ir;
    logic       en;
    logic       tdo;
  } expect_t;

  expect_t     expQ[$];
  logic [31:0] updQ[$];
  int          checks = 0;
  int          failures = 0;

  // Reference TAP: state index plus the IEEE 1149.1 transition table, shift registers as bit queues (LSB at front).
  int   mState = 0;
  logic [4:0] mIr = IDCODE_INST;
  bit   irQ[$];
  bit   drQ[$];
  int   nextOn0[16] = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};
  int   nextOn1[16] = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic [31:0] packQ(input bit q[$]);
    logic [31:0] v = 32'h0;
    for (int i = 0; i < q.size() && i < 32; i++) v[i] = q[i];
    return v;
  endfunction

  // One full TCK period: predict what the DUT shows at this rise, advance the model, then drive the pins.
  task automatic applyStimulus(input bit tmsV, input bit tdiV);
    expect_t e;
    logic [31:0] capVal;
    int capWidth;
    int ns;
    e.state = mState;
    e.ir    = mIr;
    e.en    = (mState == 4 || mState == 11);
    e.tdo   = 1'b0;
    if (mState == 11 && irQ.size() > 0) e.tdo = irQ[0];
    if (mState == 4 && drQ.size() > 0)  e.tdo = drQ[0];
    expQ.push_back(e);
    case (mState)
      10: begin
        irQ.delete();
        irQ.push_back(1'b1);
        repeat (4) irQ.push_back(1'b0);
      end
      11: begin
        void'(irQ.pop_front());
        irQ.push_back(tdiV);
      end
      3: begin
        if (mIr == IDCODE_INST)    begin capVal = IDCODE_VALUE; capWidth = 32; end
        else if (mIr == USER_INST) begin capVal = userCapture;  capWidth = 32; end
        else                       begin capVal = 32'h0;        capWidth = 1;  end
        drQ.delete();
        for (int i = 0; i < capWidth; i++) drQ.push_back(capVal[i]);
      end
      4: begin
        void'(drQ.pop_front());
        drQ.push_back(tdiV);
      end
      default: ;
    endcase
    ns = tmsV ? nextOn1[mState] : nextOn0[mState];
    if (ns == 0) mIr = IDCODE_INST;
    mState = ns;
    if (mState == 15) mIr = packQ(irQ) & 32'h1F;
    if (mState == 8 && mIr == USER_INST) updQ.push_back(packQ(drQ));
    @(negedge clock);
    tms = tmsV;
    tdi = tdiV;
    repeat (4) @(negedge clock);
    tck = 1'b1;
    repeat (4) @(negedge clock);
    tck = 1'b0;
  endtask

  task automatic gotoTlr();
    repeat (5) applyStimulus(1'b1, 1'b0);
  endtask

  task automatic irScan(input logic [4:0] v);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(i == 4, v[i]);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
  endtask

  // A pauseAt index inside the scan detours through EXIT1/PAUSE/EXIT2 after that bit.
  task automatic drScan(input logic [31:0] v, input int n, input int pauseAt);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    for (int i = 0; i < n; i++) begin
      bit isLast;
      isLast = (i == n - 1);
      if (i == pauseAt && !isLast) begin
        applyStimulus(1'b1, v[i]);
        applyStimulus(1'b0, 1'b0);
        repeat (3) applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
      end else begin
        applyStimulus(isLast, v[i]);
      end
    end
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
  endtask

  always @(posedge tck) begin
    expect_t e;
    if (expQ.size() == 0) begin
      checkOutput("tck_expect_underflow", 32'd1, 32'd0);
    end else begin
      e = expQ.pop_front();
      checkOutput("tap_state", 32'(tapState), e.state);
      checkOutput("ir_value", 32'(irValue), 32'(e.ir));
      checkOutput("tdo_en", 32'(tdoEn), 32'(e.en));
      checkOutput("tdo", 32'(tdo), 32'(e.tdo));
    end
  end

  always @(negedge clock) begin
    logic [31:0] expData;
    if (updValid) begin
      if (updQ.size() == 0) begin
        checkOutput("unexpected_update_pulse", 32'd1, 32'd0);
      end else begin
        expData = updQ.pop_front();
        checkOutput("user_update_data", userUpdate, expData);
      end
    end
  end

  initial begin
    #800000;
    $display("[TB] FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [4:0] irPick;
    int         op;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      checkOutput("idle_reset_state", {22'h0, tapState, irValue, tdoEn, updValid}, {22'h0, 4'd0, IDCODE_INST, 1'b0, 1'b0});
    end

    $display("[TB] IDCODE scan");
    gotoTlr();
    drScan(32'h0, 32, -1);

    $display("[TB] USER scan");
    irScan(USER_INST);
    userCapture = 32'hCAFEF00D;
    drScan(32'hDEADBEEF, 32, -1);
    repeat (4) @(negedge clock);
    checkOutput("user_update_deadbeef", userUpdate, 32'hDEADBEEF);

    $display("[TB] TLR from SHIFT_DR");
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    gotoTlr();
    repeat (4) @(negedge clock);
    checkOutput("tlr_state", 32'(tapState), 32'd0);
    checkOutput("tlr_ir", 32'(irValue), 32'(IDCODE_INST));

    $display("[TB] BYPASS scans");
    irScan(5'h1F);
    drScan(32'hA5, 8, -1);
    irScan(5'h07);
    drScan(32'hA5, 8, -1);

    $display("[TB] TRSTn abort");
    irScan(USER_INST);
    userCapture = $urandom;
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    repeat (10) applyStimulus(1'b0, 1'($urandom_range(0, 1)));
    repeat (2) @(negedge clock);
    trstn = 1'b0;
    repeat (4) @(negedge clock);
    trstn = 1'b1;
    mState = 0;
    mIr = IDCODE_INST;
    repeat (3) @(negedge clock);
    checkOutput("trst_state", 32'(tapState), 32'd0);
    checkOutput("trst_tdo_en", 32'(tdoEn), 32'd0);
    checkOutput("trst_ir", 32'(irValue), 32'(IDCODE_INST));
    gotoTlr();

    $display("[TB] reset mid SHIFT_IR");
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    repeat (3) applyStimulus(1'b0, 1'($urandom_range(0, 1)));
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    checkOutput("rst_outputs", {16'h0, tapState, irValue, tdo, tdoEn, updValid, 4'h0},
                {16'h0, 4'd0, IDCODE_INST, 1'b0, 1'b0, 1'b0, 4'h0});
    checkOutput("rst_user_data", userUpdate, 32'h0);
    reset = 1'b0;
    mState = 0;
    mIr = IDCODE_INST;
    irQ.delete();
    drQ.delete();
    gotoTlr();

    $display("[TB] randomized traffic");
    for (int it = 0; it < 25; it++) begin
      op = $urandom_range(0, 2);
      if (op == 0) begin
        case ($urandom_range(0, 2))
          0:       irPick = IDCODE_INST;
          1:       irPick = USER_INST;
          default: irPick = 5'($urandom);
        endcase
        irScan(irPick);
      end else if (op == 1) begin
        userCapture = $urandom;
        drScan($urandom, $urandom_range(1, 32), $urandom_range(0, 40));
      end else begin
        repeat ($urandom_range(5, 20)) applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        gotoTlr();
      end
    end

    gotoTlr();
    repeat (20) @(negedge clock);
    checkOutput("expect_queue_drained", 32'(expQ.size()), 32'd0);
    checkOutput("update_queue_drained", 32'(updQ.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/jtag_tap_responder.md
Name: jtag_tap_responder

Overview:
- Target-side JTAG TAP that responds to the testbench JTAG driver (TCK/TMS/TDI in, TDO out).
- Oversamples the JTAG pins on the single system clock instead of running a TCK domain.
- Implements the IEEE 1149.1 16-state TAP FSM, an instruction register, and the IDCODE, BYPASS and USER data registers.
- Used as a loopback target for bring-up of the JTAG VPI flow, and as a debug-port front end.

Parameters:
- IR_WIDTH, 5, instruction register width.
- DR_WIDTH, 32, USER data register width.
- IDCODE_VALUE, 32'h0EE19401, value captured by IDCODE; bit 0 must be 1.
- IDCODE_INST, 5'h01, IDCODE opcode; also the IR reset value.
- USER_INST, 5'h10, USER opcode.

Ports:
- clock  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- io_jtag_TCK  input  1  asynchronous JTAG clock.
- io_jtag_TMS  input  1  asynchronous mode select.
- io_jtag_TDI  input  1  asynchronous data in.
- io_jtag_TRSTn  input  1  asynchronous test reset, active low.
- io_jtag_TDO  output  1  data out; registered.
- io_jtag_TDO_en  output  1  high while TDO is being driven.
- user_capture_data  input  DR_WIDTH  value loaded into the USER DR in Capture-DR.
- user_update_data  output  DR_WIDTH  USER DR contents latched in Update-DR.
- user_update_valid  output  1  one-clock pulse when user_update_data changes.
- tap_state  output  4  current TAP state.
- ir_value  output  IR_WIDTH  current instruction.

Behaviour:
- Reset is synchronous and active-high. Clock is clock; reset is reset.
- Synchronizers: TCK, TMS, TDI and TRSTn each pass through a 2-FF synchronizer; TCK gets a third stage for edge detection.
  - tck_rise = sync==1 and prev==0.
  - tck_fall = sync==0 and prev==1.
  - TCK high and low times must each be at least 3 clocks. Faster TCK is unsupported; edges may be lost.
  - Rising-edge actions complete 3 clocks after the pin edge.
- State encoding:
  - 0 TLR, 1 RTI, 2 SEL_DR, 3 CAP_DR, 4 SHIFT_DR, 5 EXIT1_DR, 6 PAUSE_DR, 7 EXIT2_DR
  - 8 UPD_DR, 9 SEL_IR, 10 CAP_IR, 11 SHIFT_IR, 12 EXIT1_IR, 13 PAUSE_IR, 14 EXIT2_IR, 15 UPD_IR
  - Transitions follow standard 1149.1 on tck_rise using synchronized TMS. SEL_IR with TMS=1 goes to TLR.
- Instruction decode:
  - IDCODE_INST selects the 32-bit IDCODE register.
  - USER_INST selects the DR_WIDTH USER register.
  - All-ones and every undefined opcode select the 1-bit BYPASS register.
- On tck_rise, using the state before the transition:
  - CAP_IR: ir_shift <= {0..0,2'b01}.
  - CAP_DR: selected shift register <= IDCODE_VALUE, user_capture_data, or 0 (BYPASS).
  - SHIFT_IR / SHIFT_DR: shift right; TDI enters the MSB; the LSB is discarded.
- On tck_fall:
  - If state is SHIFT_IR or SHIFT_DR: TDO <= shift[0] and TDO_en <= 1. Otherwise TDO <= 0 and TDO_en <= 0.
  - UPD_IR: ir_value <= ir_shift.
  - UPD_DR with USER selected: user_update_data <= user shift register; user_update_valid high for exactly that one clock.
- TLR entry (TMS=1 path, or synchronized TRSTn low): ir_value <= IDCODE_INST on that clock.
  - TRSTn low forces tap_state=0 and TDO_en=0 and holds them, overriding any concurrent TCK edge.
- Reset values:
  - tap_state=0, ir_value=IDCODE_INST.
  - TDO=0, TDO_en=0.
  - user_update_data=0, user_update_valid=0.
  - All shift registers 0; synchronizers cleared to TCK=0, TRSTn=1.
- Boundary conditions:
  - reset mid-scan aborts the scan; no update pulse is generated.
  - An instruction change takes effect only at UPD_IR. A DR scan in progress keeps its selected register.
  - Pause states hold shift contents indefinitely.
  - Simultaneous tck_rise and tck_fall cannot occur, given synchronizer depth.

Test Plan:
- Reset then idle -> tap_state=0, ir_value=0x01, TDO_en=0, user_update_valid=0 for 100 clocks.
- From SHIFT_DR, TMS=1 for 5 TCK rises -> tap_state=0; ir_value=0x01 after a prior IR=0x10 load.
- TLR, TMS 0,1,0,0, then 32 shifts TDI=0 -> TDO serial LSB-first = 0x0EE19401; TDO_en high only in SHIFT_DR.
- IR scan 0x10 (captured IR reads back 0b00001), then DR scan with TDI=0xDEADBEEF and user_capture_data=0xCAFEF00D:
  - TDO reads 0xCAFEF00D.
  - At UPD_DR: user_update_data=0xDEADBEEF and user_update_valid high for exactly 1 clock.
- IR=0x1F, shift 8 bits of 0xA5 in SHIFT_DR -> TDO = 0 followed by the TDI bits delayed by one TCK. Repeat with IR=0x07 (undefined) -> identical result.
- Two mid-scan aborts:
  - TRSTn low for 4 clocks mid SHIFT_DR (USER) -> tap_state=0, TDO_en=0, no update pulse, ir_value=0x01.
  - reset pulse mid SHIFT_IR -> all outputs at reset values on the next clock.
